// File: rtl/rock_actuator.sv
// rock_actuator
//   Receiving end of the controller's A/F command interface. Turns an
//   amplitude code (A) and a frequency code (F) into a triangular signed
//   cradle-position trajectory, a direction bit and a servo PWM drive.
//   New settings are latched only at the centre position, so the motion
//   never jumps.
//
//   Optional feature (compile-time macro SOFT_START_EN): each latch raises
//   the active amplitude by at most one code, so the swing grows one code
//   per half-cycle. Decreases still take effect in one step.
//
// Ports
//   clk      in   system clock
//   reset    in   asynchronous, active-low reset
//   A[2:0]   in   amplitude code (0 = stop)
//   F[2:0]   in   frequency code (0 = stop)
//   pos[7:0] out  signed cradle position, two's complement
//   dir      out  1 = moving toward +, 0 = moving toward -
//   center   out  high while pos == 0
//   applied  out  one-cycle pulse when a changed A/F pair is latched
//   pwm      out  servo PWM drive
module rock_actuator #(
  parameter int TICK_BASE  = 4096, // clocks per position step at F=7
  parameter int STEP_PER_A = 16    // position units per amplitude code
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] A,
  input  logic [2:0] F,
  output logic [7:0] pos,
  output logic       dir,
  output logic       center,
  output logic       applied,
  output logic       pwm
);

  typedef enum logic [1:0] {ST_IDLE, ST_SWING, ST_RETURN} state_t;

  state_t            state_q, state_d;
  logic signed [7:0] pos_q, pos_d;
  logic              dir_q, dir_d;
  logic              applied_q, applied_d;
  logic              pwm_q, pwm_d;
  logic [2:0]        a_act_q, a_act_d;
  logic [2:0]        f_act_q, f_act_d;
  logic [23:0]       presc_q, presc_d;
  logic [7:0]        pwm_cnt_q, pwm_cnt_d;

  logic [23:0]       period_m1;
  logic              tick;
  logic              run;
  logic signed [7:0] lim;
  logic signed [7:0] pos_step, pos_home;
  logic              dir_step, dir_home;
  logic [2:0]        a_next;
  logic [7:0]        duty;

  // Step period halves with every frequency code above 1.
  assign period_m1 = (24'(TICK_BASE) << (3'd7 - f_act_q)) - 24'd1;
  assign tick      = (state_q != ST_IDLE) && (presc_q == period_m1);
  assign run       = (A != 3'd0) && (F != 3'd0);
  assign lim       = 8'(int'(a_act_q) * STEP_PER_A);

  // Adding 128 modulo 256 to a two's-complement byte only flips its MSB.
  assign duty = {~pos_q[7], pos_q[6:0]};

`ifdef SOFT_START_EN
  assign a_next = (A > a_act_q) ? a_act_q + 3'd1 : A;
`else
  assign a_next = A;
`endif

  // Next point on the triangle, turning around at +/-lim.
  always_comb begin
    pos_step = pos_q;
    dir_step = dir_q;
    if (dir_q && (pos_q == lim)) begin
      dir_step = 1'b0;
      pos_step = pos_q - 8'sd1;
    end else if (!dir_q && (pos_q == -lim)) begin
      dir_step = 1'b1;
      pos_step = pos_q + 8'sd1;
    end else if (dir_q) begin
      pos_step = pos_q + 8'sd1;
    end else begin
      pos_step = pos_q - 8'sd1;
    end
  end

  // One unit toward the centre; dir follows the direction of travel.
  always_comb begin
    pos_home = pos_q;
    dir_home = dir_q;
    if (pos_q < 8'sd0) begin
      pos_home = pos_q + 8'sd1;
      dir_home = 1'b1;
    end else if (pos_q > 8'sd0) begin
      pos_home = pos_q - 8'sd1;
      dir_home = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    a_act_d   = a_act_q;
    f_act_d   = f_act_q;
    applied_d = 1'b0;
    presc_d   = tick ? '0 : presc_q + 24'd1;
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    pwm_d     = (state_q != ST_IDLE) && (pwm_cnt_q < duty);
    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        pos_d   = '0;
        dir_d   = 1'b0;
        if (run) begin
          state_d   = ST_SWING;
          a_act_d   = a_next;
          f_act_d   = F;
          applied_d = 1'b1;
          dir_d     = 1'b1;
        end
      end
      ST_SWING: begin
        // A stop request is honoured at once; a tick in the same cycle
        // already moves toward the centre.
        if (!run) begin
          state_d = ST_RETURN;
          if (tick) begin
            pos_d = pos_home;
            dir_d = dir_home;
          end
        end else if (tick) begin
          pos_d = pos_step;
          dir_d = dir_step;
          if ((pos_step == 8'sd0) && ((A != a_act_q) || (F != f_act_q))) begin
            a_act_d   = a_next;
            f_act_d   = F;
            applied_d = 1'b1;
            presc_d   = '0;
          end
        end
      end
      ST_RETURN: begin
        if (pos_q == 8'sd0) begin
          state_d = ST_IDLE;
          dir_d   = 1'b0;
          a_act_d = '0;
          f_act_d = '0;
          presc_d = '0;
        end else if (tick) begin
          pos_d = pos_home;
          dir_d = dir_home;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      applied_q <= 1'b0;
      pwm_q     <= 1'b0;
      a_act_q   <= '0;
      f_act_q   <= '0;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      applied_q <= applied_d;
      pwm_q     <= pwm_d;
      a_act_q   <= a_act_d;
      f_act_q   <= f_act_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pos     = pos_q;
  assign dir     = dir_q;
  assign center  = (pos_q == 8'sd0);
  assign applied = applied_q;
  assign pwm     = pwm_q;

endmodule

// File: tb/tb_rock_actuator.sv
// tb_rock_actuator
//   Self-checking bench for rock_actuator (TICK_BASE=4, STEP_PER_A=16).
//   A reference model predicts every cycle's outputs from the trajectory
//   rules (triangle wave as a function of step count, tick times from
//   elapsed clocks) and queues them; a monitor pops and compares on the
//   falling edge. Directed checks cover latency, periods, PWM duty, stop,
//   reset and amplitude growth; a random phase follows.
`timescale 1ns/1ps
module tb_rock_actuator;

  localparam int TB_TICK = 4;
  localparam int TB_STEP = 16;
  localparam int M_IDLE   = 0;
  localparam int M_SWING  = 1;
  localparam int M_RETURN = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] A     = 3'd0;
  logic [2:0] F     = 3'd0;
  logic [7:0] pos;
  logic       dir, center, applied, pwm;

  rock_actuator #(.TICK_BASE(TB_TICK), .STEP_PER_A(TB_STEP)) dut (
    .clk(clk), .reset(reset), .A(A), .F(F), .pos(pos), .dir(dir),
    .center(center), .applied(applied), .pwm(pwm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name, input int budget);
    checks++;
    errors++;
    $display("FAIL %s: condition not reached within %0d cycles (t=%0t)", name, budget, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int pos;
    bit dir;
    bit applied;
    bit pwm;
  } exp_t;

  exp_t exp_q[$];

  int m_st = M_IDLE, m_pos = 0, m_k = 0, m_aa = 0, m_fa = 0;
  int m_since = 0, m_edges = 0;
  bit m_dir = 1'b0;

  // Position after k steps of a triangle of amplitude L starting at 0 upward.
  function automatic int tri_pos(input int k, input int L);
    int ph;
    ph = k % (4 * L);
    if (ph <= L) return ph;
    else if (ph <= 3 * L) return 2 * L - ph;
    else return ph - 4 * L;
  endfunction

  // Direction flips only on the step after an extreme is reached.
  function automatic bit tri_dir(input int k, input int L);
    int ph;
    ph = k % (4 * L);
    return (ph <= L) || (ph > 3 * L);
  endfunction

  function automatic int amp_target();
`ifdef SOFT_START_EN
    return (int'(A) > m_aa) ? m_aa + 1 : int'(A);
`else
    return int'(A);
`endif
  endfunction

  initial begin : model
    exp_t e;
    bit   run, tick, latched, going_neg;
    int   per, lim;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_st = M_IDLE; m_pos = 0; m_dir = 1'b0; m_k = 0;
        m_aa = 0; m_fa = 0; m_since = 0; m_edges = 0;
        e = '{0, 1'b0, 1'b0, 1'b0};
        exp_q.delete();
        exp_q.push_back(e);
      end else begin
        run       = (A != 3'd0) && (F != 3'd0);
        per       = (m_fa != 0) ? (TB_TICK << (7 - m_fa)) : 1;
        tick      = (m_st != M_IDLE) && ((m_since % per) == per - 1);
        e.pwm     = (m_st != M_IDLE) && ((m_edges % 256) < (m_pos + 128));
        e.applied = 1'b0;
        latched   = 1'b0;
        case (m_st)
          M_IDLE: begin
            if (run) begin
              m_aa = amp_target(); m_fa = int'(F); e.applied = 1'b1;
              m_k = 0; m_pos = 0; m_dir = 1'b1; m_st = M_SWING;
            end
            m_since = 0;
          end
          M_SWING: begin
            if (!run) begin
              m_st = M_RETURN;
              if (tick && m_pos > 0) begin m_pos--; m_dir = 1'b0; end
              else if (tick && m_pos < 0) begin m_pos++; m_dir = 1'b1; end
            end else if (tick) begin
              lim = m_aa * TB_STEP;
              m_k++;
              m_pos = tri_pos(m_k, lim);
              m_dir = tri_dir(m_k, lim);
              if (m_pos == 0 && (int'(A) != m_aa || int'(F) != m_fa)) begin
                going_neg = (m_k % (4 * lim)) == 2 * lim;
                m_aa = amp_target(); m_fa = int'(F);
                e.applied = 1'b1; latched = 1'b1;
                m_k = going_neg ? 2 * m_aa * TB_STEP : 0;
              end
            end
            m_since = latched ? 0 : m_since + 1;
          end
          default: begin
            if (m_pos == 0) begin
              m_st = M_IDLE; m_dir = 1'b0; m_aa = 0; m_fa = 0; m_since = 0;
            end else begin
              if (tick && m_pos > 0) begin m_pos--; m_dir = 1'b0; end
              else if (tick && m_pos < 0) begin m_pos++; m_dir = 1'b1; end
              m_since++;
            end
          end
        endcase
        m_edges++;
        e.pos = m_pos;
        e.dir = m_dir;
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pos",     int'($signed(pos)), e.pos);
        check("dir",     int'(dir),          int'(e.dir));
        check("center",  int'(center),       (e.pos == 0) ? 1 : 0);
        check("applied", int'(applied),      int'(e.applied));
        check("pwm",     int'(pwm),          int'(e.pwm));
      end
    end
  end

  // ---------------- stimulus helpers (posedge+2 phase) ----------------
  task automatic wait_pos_change(output int n, input int budget);
    logic [7:0] v;
    v = pos;
    n = 0;
    while (pos == v && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (pos == v) fail_timeout("pos_change", budget);
  endtask

  task automatic wait_pos(input int target, input bit use_dir, input bit dval,
                          input int budget, input string name);
    int n;
    n = 0;
    while (!(int'($signed(pos)) == target && (!use_dir || dir == dval)) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (!(int'($signed(pos)) == target && (!use_dir || dir == dval)))
      fail_timeout(name, budget);
  endtask

  task automatic track(input int cycles, output int mx, output int mn, output int napp);
    mx = int'($signed(pos));
    mn = mx;
    napp = 0;
    repeat (cycles) begin
      @(posedge clk); #2;
      if (int'($signed(pos)) > mx) mx = int'($signed(pos));
      if (int'($signed(pos)) < mn) mn = int'($signed(pos));
      napp += int'(applied);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    int n, hi, mx, mn, napp;

    // Reset, then idle with stop codes.
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    n = 0;
    repeat (100) begin
      @(posedge clk); #2;
      if (pos != 8'd0 || dir || !center || applied || pwm) n++;
    end
    check("idle_quiet_cycles", n, 0);

    // A=1, F=7: latch, first step after 4 further clocks, 4-clock period.
    A = 3'd1; F = 3'd7;
    wait_pos_change(n, 20);
    check("f7_first_step_latency", n, 5);
    wait_pos_change(n, 20);
    check("f7_step_period", n, 4);
    track(260, mx, mn, napp);
    check("a1_peak", mx, 16);
    check("a1_trough", mn, -16);

    // Amplitude raised mid-swing: only effective after the centre crossing.
    wait_pos(5, 1'b1, 1'b1, 300, "reach_pos5_up");
    A = 3'd2;
    track(300, mx, mn, napp);
    check("a2_deferred_peak", mx, 16);
    check("a2_next_trough", mn, -32);
    check("a2_applied_pulses", napp, 1);

    // Stop mid-swing at +10 moving up.
    wait_pos(10, 1'b1, 1'b1, 300, "reach_pos10_up");
    A = 3'd0;
    repeat (60) begin @(posedge clk); #2; end
    check("stop_pos", int'($signed(pos)), 0);
    check("stop_dir", int'(dir), 0);
    track(50, mx, mn, napp);
    check("stop_no_motion", mx - mn, 0);

    // F=1: 256-clock steps; PWM duty over a held position.
    A = 3'd1; F = 3'd1;
    wait_pos_change(n, 400);
    check("f1_first_step_latency", n, 257);
    wait_pos_change(n, 400);
    check("f1_step_period", n, 256);
    wait_pos_change(n, 400);
    check("pwm_window_pos", int'($signed(pos)), 3);
    hi = 0;
    repeat (256) begin
      @(posedge clk);
      @(negedge clk);
      hi += int'(pwm);
    end
    check("pwm_high_count", hi, 131);

    // Reset mid-operation, then again mid-step at pos=-7.
    @(posedge clk); #3 reset = 1'b0;
    #1;
    check("rst1_pos", int'(pos), 0);
    check("rst1_center", int'(center), 1);
    A = 3'd1; F = 3'd7;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    wait_pos(-7, 1'b0, 1'b0, 400, "reach_neg7");
    #1 reset = 1'b0;
    #1;
    check("rst2_pos", int'(pos), 0);
    check("rst2_applied", int'(applied), 0);
    check("rst2_pwm", int'(pwm), 0);
    check("rst2_center", int'(center), 1);

    // A=3 from idle: peak 48, stepped in one or three latches.
    A = 3'd3; F = 3'd7;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    track(800, mx, mn, napp);
    check("a3_peak", mx, 48);
`ifdef SOFT_START_EN
    check("a3_soft_applied_pulses", napp, 3);
`else
    check("a3_direct_applied_pulses", napp, 1);
`endif

    // Random codes held for random spans; the monitor checks every cycle.
    repeat (40) begin
      A = 3'($urandom_range(0, 7));
      F = 3'($urandom_range(4, 7));
      repeat ($urandom_range(20, 300)) @(posedge clk);
      #2;
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
